// File: rtl/axi_arbiter.sv
// Two-master AXI arbiter: m0 read-only, m1 read/write, one slave, one transaction at a time.
// Optional macro ARB_RR_EN selects round-robin between masters; default is fixed priority.
module axi_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0 read
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    input  logic [1:0]            m0_arburst,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    output logic                  m0_rlast,
    input  logic                  m0_rready,
    // master 1 read
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    input  logic [1:0]            m1_arburst,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    output logic                  m1_rlast,
    input  logic                  m1_rready,
    // master 1 write
    input  logic [ADDR_WIDTH-1:0] m1_awaddr,
    input  logic                  m1_awvalid,
    input  logic [1:0]            m1_awburst,
    input  logic [7:0]            m1_awlen,
    output logic                  m1_awready,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [7:0]            m1_wstrb,
    input  logic                  m1_wlast,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    // slave side
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    output logic [1:0]            s_arburst,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    input  logic                  s_rlast,
    output logic                  s_rready,
    output logic [ADDR_WIDTH-1:0] s_awaddr,
    output logic                  s_awvalid,
    output logic [1:0]            s_awburst,
    output logic [7:0]            s_awlen,
    input  logic                  s_awready,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic [7:0]            s_wstrb,
    output logic                  s_wlast,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic [1:0]            grant
);

    // state | meaning
    // IDLE  | no owner, everything quiet, arbitrate on requests
    // RD0   | master 0 read owns AR/R until last R beat
    // RD1   | master 1 read owns AR/R until last R beat
    // WR1   | master 1 write owns AW/W/B until B handshake
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD0  = 2'b01,
        RD1  = 2'b10,
        WR1  = 2'b11
    } state_t;

    state_t state;

    assign grant = state;

`ifdef ARB_RR_EN
    logic last_m1;
    logic m1_req;
    assign m1_req = m1_awvalid | m1_arvalid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
`ifdef ARB_RR_EN
            last_m1 <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef ARB_RR_EN
                    // m1 wins unless m0 is also waiting and m1 had the last turn
                    if (m1_req && !(m0_arvalid && last_m1)) begin
                        state   <= m1_awvalid ? WR1 : RD1;
                        last_m1 <= 1'b1;
                    end else if (m0_arvalid) begin
                        state   <= RD0;
                        last_m1 <= 1'b0;
                    end
`else
                    if (m1_awvalid)      state <= WR1;
                    else if (m1_arvalid) state <= RD1;
                    else if (m0_arvalid) state <= RD0;
`endif
                end
                RD0, RD1: if (s_rvalid && s_rready && s_rlast) state <= IDLE;
                WR1:      if (s_bvalid && s_bready) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m0_rlast   = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_rlast   = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_arburst  = 2'b00;
        s_arlen    = 8'h00;
        s_arsize   = 3'b000;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_awburst  = 2'b00;
        s_awlen    = 8'h00;
        s_wdata    = '0;
        s_wstrb    = 8'h00;
        s_wlast    = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        case (state)
            RD0: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid;
                s_arburst  = m0_arburst;
                s_arlen    = m0_arlen;
                s_arsize   = m0_arsize;
                m0_arready = s_arready;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
                m0_rlast   = s_rlast;
                s_rready   = m0_rready;
            end
            RD1: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid;
                s_arburst  = m1_arburst;
                s_arlen    = m1_arlen;
                s_arsize   = m1_arsize;
                m1_arready = s_arready;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
                m1_rlast   = s_rlast;
                s_rready   = m1_rready;
            end
            WR1: begin
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid;
                s_awburst  = m1_awburst;
                s_awlen    = m1_awlen;
                m1_awready = s_awready;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wlast    = m1_wlast;
                s_wvalid   = m1_wvalid;
                m1_wready  = s_wready;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
                s_bready   = m1_bready;
            end
            default: ;
        endcase
    end

endmodule
